add7_host: RTL and testbench

//   Host-side driver for the synthesized 7-operand adder kernel ("main": r_enable/init_*/w_enable/result).

---
 rtl/add7_host.sv | 166 ++++++++++++++++
 tb/tb_add7_host.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/add7_host.sv
// add7_host: host-side driver for the 7-operand adder kernel.
// It collects operands from a valid/ready stream, loads them into the kernel with a one-cycle
// strobe, waits for the kernel's done level (with a watchdog), and returns the result on a
// valid/ready output stream. One job is in flight at a time.
module add7_host #(
   parameter int unsigned N_ARGS  = 7,
   parameter int unsigned ARG_W   = 13,
   parameter int unsigned RES_W   = 13,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   // operand stream
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [ARG_W-1:0]          s_data,
   input  logic                      s_last,
   // kernel side
   output logic                      k_r_enable,
   output logic [N_ARGS*ARG_W-1:0]   k_args,
   input  logic                      k_w_enable,
   input  logic [RES_W-1:0]          k_result,
   // result stream
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [RES_W-1:0]          m_data,
   output logic                      m_error,
   output logic                      busy
);

   localparam int unsigned CNT_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_ARGS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StCollect,
      StLaunch,
      StWait,
      StOut
   } state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic [N_ARGS*ARG_W-1:0]   args_q, args_d;
   logic                      r_enable_q, r_enable_d;
   logic                      m_valid_q, m_valid_d;
   logic [RES_W-1:0]          m_data_q, m_data_d;
   logic                      m_error_q, m_error_d;

   logic                      in_collect;
   logic                      beat;
   logic                      at_last_slot;
   logic                      timer_expired;

   assign in_collect    = (state_q == StCollect);
   // Gated by rst_n so the stream never sees ready while the block is held in reset.
   assign s_ready       = in_collect & rst_n;
   assign beat          = s_valid & s_ready;
   assign at_last_slot  = (count_q == LAST_SLOT);
   assign timer_expired = (timer_q == TMR_LAST);
   assign busy          = ~(in_collect && (count_q == '0));

   assign k_r_enable = r_enable_q;
   assign k_args     = args_q;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_error    = m_error_q;

   // Next-state and registered-output logic for the job sequencer.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      timer_d    = timer_q;
      args_d     = args_q;
      r_enable_d = 1'b0;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_error_d  = m_error_q;

      unique case (state_q)
         StCollect: begin
            if (beat) begin
               for (int i = 0; i < N_ARGS; i++) begin
                  if (count_q == CNT_W'(i)) begin
                     args_d[i*ARG_W +: ARG_W] = s_data;
                  end
               end
               if (s_last && at_last_slot) begin
                  state_d    = StLaunch;
                  count_d    = '0;
                  r_enable_d = 1'b1;
               end else if (s_last || at_last_slot) begin
                  // Framing error: report it without ever starting the kernel.
                  state_d   = StOut;
                  count_d   = '0;
                  m_valid_d = 1'b1;
                  m_data_d  = '0;
                  m_error_d = 1'b1;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end

         StLaunch: begin
            // Done flag is deliberately not looked at here: it may be stale from the last job.
            state_d = StWait;
            timer_d = '0;
         end

         StWait: begin
            if (k_w_enable) begin
               state_d   = StOut;
               m_valid_d = 1'b1;
               m_data_d  = k_result;
               m_error_d = 1'b0;
            end else if (timer_expired) begin
               state_d   = StOut;
               m_valid_d = 1'b1;
               m_data_d  = '0;
               m_error_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         StOut: begin
            if (m_ready) begin
               state_d   = StCollect;
               m_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = StCollect;
         end
      endcase
   end

   // State and output registers; reset abandons any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StCollect;
         count_q    <= '0;
         timer_q    <= '0;
         args_q     <= '0;
         r_enable_q <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_error_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         args_q     <= args_d;
         r_enable_q <= r_enable_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_error_q  <= m_error_d;
      end
   end

endmodule

// File: tb/tb_add7_host.sv
// Bench for add7_host: behavioural kernel (loads on r_enable, done level 7 cycles later),
// directed jobs with a scoreboard of expected {error, data} results.
module tb_add7_host;

   localparam int N  = 7;
   localparam int AW = 13;
   localparam int RW = 13;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [AW-1:0]   s_data = '0;
   logic            s_last = 1'b0;
   logic            k_r_enable;
   logic [N*AW-1:0] k_args;
   logic            k_w_enable = 1'b0;
   logic [RW-1:0]   k_result = '0;
   logic            m_valid;
   logic            m_ready = 1'b1;
   logic [RW-1:0]   m_data;
   logic            m_error;
   logic            busy;

   int              checks = 0;
   int              errors = 0;
   logic [RW:0]     sb_q[$];
   int unsigned     ops[N];
   logic            hang = 1'b0;
   logic [3:0]      kcnt = '0;
   int              pulses = 0;

   always #5 clk = ~clk;

   add7_host #(
      .N_ARGS (N),
      .ARG_W  (AW),
      .RES_W  (RW),
      .TIMEOUT(TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .k_r_enable(k_r_enable),
      .k_args    (k_args),
      .k_w_enable(k_w_enable),
      .k_result  (k_result),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_error   (m_error),
      .busy      (busy)
   );

   function automatic logic [RW-1:0] ksum(input logic [N*AW-1:0] a);
      logic [RW-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s = s + RW'(a[i*AW +: AW]);
      return s;
   endfunction

   // Kernel model: done level is held until the next load strobe.
   always @(posedge clk) begin
      if (k_r_enable) begin
         pulses     <= pulses + 1;
         kcnt       <= 4'd7;
         k_w_enable <= 1'b0;
         k_result   <= ksum(k_args);
      end else if (kcnt != 0) begin
         kcnt <= kcnt - 4'd1;
         if (kcnt == 4'd1 && !hang) k_w_enable <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send_beat(input logic [AW-1:0] d, input logic last);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("s_ready_wait", 0, 1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic run_job(input int nb, input int hold);
      logic [RW:0]     exp;
      logic [RW:0]     got;
      logic [RW-1:0]   sum;
      logic [N*AW-1:0] packed_ops;
      int              p0;
      int              n;
      int              exp_lat;
      sum        = '0;
      packed_ops = '0;
      for (int i = 0; i < N; i++) begin
         sum = sum + RW'(ops[i]);
         packed_ops[i*AW +: AW] = AW'(ops[i]);
      end
      if (nb != N || hang) exp = {1'b1, {RW{1'b0}}};
      else                 exp = {1'b0, sum};
      exp_lat = (nb != N) ? 0 : (hang ? TO + 1 : 9);
      sb_q.push_back(exp);
      m_ready = (hold == 0);
      p0 = pulses;
      for (int b = 0; b < nb; b++) send_beat(AW'(ops[b]), b == nb - 1);
      if (nb == N) begin
         check("launch_strobe", k_r_enable, 1);
         check("k_args", k_args, packed_ops);
      end
      n = 0;
      while (!m_valid && n < 200) begin
         @(negedge clk);
         n++;
         if (hang && n == 30) begin
            check("busy_in_wait", busy, 1);
            check("s_ready_in_wait", s_ready, 0);
            check("strobe_single", k_r_enable, 0);
         end
      end
      check("latency", n, exp_lat);
      check("strobe_count", pulses - p0, (nb == N) ? 1 : 0);
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", m_valid, 1);
         check("hold_data", {m_error, m_data}, exp);
         check("hold_s_ready", s_ready, 0);
         check("hold_busy", busy, 1);
         @(negedge clk);
      end
      m_ready = 1'b1;
      got = {m_error, m_data};
      exp = sb_q.pop_front();
      check("result", got, exp);
      check("busy_out", busy, 1);
      @(negedge clk);
      check("valid_drop", m_valid, 0);
      check("ready_back", s_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_strobe", k_r_enable, 0);
      check("rst_k_args", k_args, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_error", m_error, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      #1;
      check("idle_s_ready", s_ready, 1);
      check("idle_busy", busy, 0);
      @(negedge clk);

      // Basic sum
      ops = '{1, 2, 3, 4, 5, 6, 7};
      run_job(N, 0);

      // Wrap modulo 2^13
      ops = '{0, 0, 0, 0, 8191, 0, 8191};
      run_job(N, 0);

      // Early s_last: framing error, then a clean job
      ops = '{1, 2, 3, 0, 0, 0, 0};
      run_job(3, 0);
      ops = '{1, 2, 3, 4, 5, 6, 7};
      run_job(N, 0);

      // Kernel never completes: watchdog
      hang = 1'b1;
      ops  = '{9, 8, 7, 6, 5, 4, 3};
      run_job(N, 0);
      hang = 1'b0;

      // Back-pressure on the result, then back-to-back jobs over a stale done flag
      ops = '{1, 2, 3, 4, 5, 6, 7};
      run_job(N, 20);
      ops = '{1, 1, 1, 1, 1, 1, 1};
      run_job(N, 0);
      ops = '{100, 200, 300, 400, 500, 600, 700};
      run_job(N, 0);

      // Reset in the middle of WAIT
      ops = '{1, 2, 3, 4, 5, 6, 7};
      for (int b = 0; b < N; b++) send_beat(AW'(ops[b]), b == N - 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_strobe", k_r_enable, 0);
      check("mid_rst_k_args", k_args, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_m_error", m_error, 0);
      check("mid_rst_s_ready", s_ready, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(N, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
